// File: rtl/dmem_store_rmw.sv
// Store path into the word-wide data RAM: sw writes directly, sb/sh read the word,
// merge the lane(s) and write it back. One request in flight at a time.
module dmem_store_rmw #(
  parameter int ADDR_W   = 14,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [31:0]       st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_type,
  output logic              st_done,
  output logic              st_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] TYPE_SB = 2'b00;
  localparam logic [1:0] TYPE_SH = 2'b01;
  localparam logic [1:0] TYPE_SW = 2'b10;
  localparam logic [2:0] LAT_INIT = 3'(READ_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        off_q;
  logic [1:0]        type_q;
  logic [15:0]       data_q;
  logic [31:0]       wdata_q;
  logic [2:0]        cnt_q;
  logic              bad_req;
  logic              unused_hi_addr;

  // Address bits above the RAM index wrap silently.
  assign unused_hi_addr = &{1'b0, st_addr[31:ADDR_W+2]};

  assign bad_req = (st_type == 2'b11)
                 || ((st_type == TYPE_SH) && st_addr[0])
                 || ((st_type == TYPE_SW) && (st_addr[1:0] != 2'b00));

  function automatic logic [31:0] merge_word(input logic [31:0] word,
                                             input logic [15:0] data,
                                             input logic [1:0]  typ,
                                             input logic [1:0]  off);
    logic [31:0] r;
    r = word;
    if (typ == TYPE_SB) begin
      case (off)
        2'd0:    r[7:0]   = data[7:0];
        2'd1:    r[15:8]  = data[7:0];
        2'd2:    r[23:16] = data[7:0];
        default: r[31:24] = data[7:0];
      endcase
    end else if (typ == TYPE_SH) begin
      if (off[1]) r[31:16] = data;
      else        r[15:0]  = data;
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (st_valid) begin
          if (bad_req)                  state_d = S_ERR;
          else if (st_type == TYPE_SW)  state_d = S_WRITE;
          else                          state_d = S_READ;
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT:  if (cnt_q == 3'd1) state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The sw data goes straight into the write register on accept; sb/sh overwrite it
  // with the merged word on the last WAIT cycle, when mem_rdata is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      type_q  <= '0;
      data_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (st_valid) begin
            addr_q  <= st_addr[ADDR_W+1:2];
            off_q   <= st_addr[1:0];
            type_q  <= st_type;
            data_q  <= st_data[15:0];
            wdata_q <= st_data;
          end
        end
        S_READ: cnt_q <= LAT_INIT;
        S_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) wdata_q <= merge_word(mem_rdata, data_q, type_q, off_q);
        end
        default: ;
      endcase
    end
  end

  assign st_ready  = (state_q == S_IDLE);
  assign st_done   = (state_q == S_WRITE) || (state_q == S_ERR);
  assign st_err    = (state_q == S_ERR);
  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_store_rmw.sv
// Bench for dmem_store_rmw: two instances (READ_LAT 1 and 3), each with its own RAM model,
// driven by a vector table, hand sequences and random stores checked against a model.
module tb_dmem_store_rmw;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        st_valid  [2];
  logic        st_ready  [2];
  logic [31:0] st_addr   [2];
  logic [31:0] st_data   [2];
  logic [1:0]  st_type   [2];
  logic        st_done   [2];
  logic        st_err    [2];
  logic [13:0] mem_addr  [2];
  logic        mem_we    [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  logic [31:0] ram     [2][16384];
  logic [31:0] rd_pipe [2][4];
  logic        poke_en   [2];
  logic [13:0] poke_idx  [2];
  logic [31:0] poke_data [2];
  int          we_cnt    [2] = '{0, 0};

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_store_rmw #(.ADDR_W(14), .READ_LAT(1)) u_dut_lat1 (
    .clk(clk), .rst(rst[0]), .st_valid(st_valid[0]), .st_ready(st_ready[0]),
    .st_addr(st_addr[0]), .st_data(st_data[0]), .st_type(st_type[0]),
    .st_done(st_done[0]), .st_err(st_err[0]), .mem_addr(mem_addr[0]),
    .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  dmem_store_rmw #(.ADDR_W(14), .READ_LAT(3)) u_dut_lat3 (
    .clk(clk), .rst(rst[1]), .st_valid(st_valid[1]), .st_ready(st_ready[1]),
    .st_addr(st_addr[1]), .st_data(st_data[1]), .st_type(st_type[1]),
    .st_done(st_done[1]), .st_err(st_err[1]), .mem_addr(mem_addr[1]),
    .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  // RAM models: instance 0 returns data one cycle after the address, instance 1 three.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (poke_en[g])     ram[g][poke_idx[g]] <= poke_data[g];
      else if (mem_we[g]) ram[g][mem_addr[g]] <= mem_wdata[g];
      rd_pipe[g][0] <= ram[g][mem_addr[g]];
      for (int i = 1; i < 4; i++) rd_pipe[g][i] <= rd_pipe[g][i-1];
      if (mem_we[g]) we_cnt[g] <= we_cnt[g] + 1;
    end
  end

  assign mem_rdata[0] = rd_pipe[0][0];
  assign mem_rdata[1] = rd_pipe[1][2];

  typedef struct {
    int          inst;
    logic [31:0] pre;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  typ;
    logic        exp_err;
    logic [31:0] exp_word;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic poke(input int inst, input logic [13:0] idx, input logic [31:0] val);
    poke_en[inst]   = 1'b1;
    poke_idx[inst]  = idx;
    poke_data[inst] = val;
    step();
    poke_en[inst] = 1'b0;
  endtask

  task automatic waitReady(input int inst);
    int guard = 0;
    while (!st_ready[inst] && guard < 50) begin
      step();
      guard++;
    end
    if (!st_ready[inst]) checkOutput("ready_timeout", 32'd0, 32'd1);
  endtask

  // Issues one store and follows it to st_done; fields are scrambled while busy.
  task automatic applyStimulus(input int inst, input logic [31:0] addr, input logic [31:0] data,
                               input logic [1:0] typ, output logic got_err,
                               output logic [31:0] got_wdata, output logic [13:0] got_addr,
                               output int lat, output int we_delta);
    int we_before;
    waitReady(inst);
    we_before       = we_cnt[inst];
    st_valid[inst]  = 1'b1;
    st_addr[inst]   = addr;
    st_data[inst]   = data;
    st_type[inst]   = typ;
    step();
    st_valid[inst]  = 1'b0;
    st_addr[inst]   = $urandom;
    st_data[inst]   = $urandom;
    st_type[inst]   = 2'($urandom_range(0, 3));
    lat = 1;
    while (!st_done[inst] && lat < 20) begin
      step();
      lat++;
    end
    if (!st_done[inst]) lat = -1;
    got_err   = st_err[inst];
    got_wdata = mem_wdata[inst];
    got_addr  = mem_addr[inst];
    step();
    we_delta = we_cnt[inst] - we_before;
  endtask

  function automatic void ref_store(input logic [31:0] old, input logic [31:0] addr,
                                    input logic [31:0] data, input logic [1:0] typ,
                                    output logic [31:0] nw, output logic err);
    logic [31:0] mask;
    int          sh;
    err = (typ == 2'd3) || (typ == 2'd1 && addr[0]) || (typ == 2'd2 && addr[1:0] != 2'd0);
    nw  = old;
    if (!err) begin
      if (typ == 2'd2) begin
        nw = data;
      end else begin
        mask = (typ == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
        sh   = 8 * int'(addr[1:0]);
        nw   = (old & ~(mask << sh)) | ((data & mask) << sh);
      end
    end
  endfunction

  task automatic resetDuringWait(input int inst);
    int  we_before;
    logic any_done;
    poke(inst, 14'd5, 32'h1122_3344);
    waitReady(inst);
    we_before      = we_cnt[inst];
    st_valid[inst] = 1'b1;
    st_addr[inst]  = 32'h14;
    st_data[inst]  = 32'h77;
    st_type[inst]  = 2'd0;
    step();
    st_valid[inst] = 1'b0;
    step();
    rst[inst] = 1'b1;
    step();
    rst[inst] = 1'b0;
    checkOutput("rstwait_ready", 32'(st_ready[inst]), 32'd1);
    checkOutput("rstwait_done", 32'(st_done[inst]), 32'd0);
    checkOutput("rstwait_we", 32'(mem_we[inst]), 32'd0);
    any_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      any_done |= st_done[inst];
      step();
    end
    checkOutput("rstwait_late_done", 32'(any_done), 32'd0);
    checkOutput("rstwait_we_count", 32'(we_cnt[inst] - we_before), 32'd0);
    checkOutput("rstwait_ram", ram[inst][5], 32'h1122_3344);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic        got_err;
    logic [31:0] got_wdata;
    logic [13:0] got_addr;
    int          lat;
    int          we_delta;
    logic [31:0] ref_ram [2][16];
    logic [31:0] exp_word;
    logic        exp_err;
    int          exp_lat;
    int          inst;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  typ;
    logic [3:0]  widx;
    logic [31:0] req_addr [3];
    logic [31:0] req_data [3];
    int          we_before;
    int          guard;

    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1; st_valid[g] = 1'b0; st_addr[g] = '0; st_data[g] = '0;
      st_type[g] = '0; poke_en[g] = 1'b0; poke_idx[g] = '0; poke_data[g] = '0;
    end
    repeat (3) step();

    for (int g = 0; g < 2; g++) begin
      checkOutput("reset_ready", 32'(st_ready[g]), 32'd1);
      checkOutput("reset_done", 32'(st_done[g]), 32'd0);
      checkOutput("reset_err", 32'(st_err[g]), 32'd0);
      checkOutput("reset_we", 32'(mem_we[g]), 32'd0);
      checkOutput("reset_addr", 32'(mem_addr[g]), 32'd0);
      checkOutput("reset_wdata", mem_wdata[g], 32'd0);
      rst[g] = 1'b0;
    end
    step();

    vecs.push_back('{0, 32'h0000_0000, 32'h0000_0010, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'hDEAD_BEEF, 1});
    vecs.push_back('{0, 32'h1122_3344, 32'h0000_0013, 32'h0000_00AA, 2'd0, 1'b0, 32'hAA22_3344, 3});
    vecs.push_back('{1, 32'h1122_3344, 32'h0000_0013, 32'h0000_00AA, 2'd0, 1'b0, 32'hAA22_3344, 5});
    vecs.push_back('{0, 32'h1122_3344, 32'h0000_0022, 32'h0000_5566, 2'd1, 1'b0, 32'h5566_3344, 3});
    vecs.push_back('{0, 32'h1122_3344, 32'h0000_0020, 32'h0000_5566, 2'd1, 1'b0, 32'h1122_5566, 3});
    vecs.push_back('{0, 32'h1122_3344, 32'h0000_0021, 32'h0000_5566, 2'd1, 1'b1, 32'h1122_3344, 1});
    vecs.push_back('{0, 32'h1122_3344, 32'h0000_0012, 32'hCAFE_F00D, 2'd2, 1'b1, 32'h1122_3344, 1});
    vecs.push_back('{0, 32'h1122_3344, 32'h0000_0030, 32'h1234_5678, 2'd3, 1'b1, 32'h1122_3344, 1});
    vecs.push_back('{0, 32'h1122_3344, 32'hABCD_0011, 32'hFFFF_FF5A, 2'd0, 1'b0, 32'h1122_5A44, 3});
    vecs.push_back('{1, 32'h1122_3344, 32'h0000_0022, 32'h0000_5566, 2'd1, 1'b0, 32'h5566_3344, 5});
    vecs.push_back('{1, 32'hA5A5_A5A5, 32'h0000_002F, 32'h0000_0012, 2'd0, 1'b0, 32'h12A5_A5A5, 5});
    vecs.push_back('{1, 32'h1122_3344, 32'h0000_0021, 32'h0000_5566, 2'd1, 1'b1, 32'h1122_3344, 1});

    foreach (vecs[v]) begin
      poke(vecs[v].inst, vecs[v].addr[15:2], vecs[v].pre);
      applyStimulus(vecs[v].inst, vecs[v].addr, vecs[v].data, vecs[v].typ,
                    got_err, got_wdata, got_addr, lat, we_delta);
      checkOutput("vec_err", 32'(got_err), 32'(vecs[v].exp_err));
      checkOutput("vec_latency", 32'(lat), 32'(vecs[v].exp_lat));
      checkOutput("vec_we_pulses", 32'(we_delta), vecs[v].exp_err ? 32'd0 : 32'd1);
      checkOutput("vec_ram_word", ram[vecs[v].inst][vecs[v].addr[15:2]], vecs[v].exp_word);
      if (!vecs[v].exp_err) begin
        checkOutput("vec_wdata", got_wdata, vecs[v].exp_word);
        checkOutput("vec_mem_addr", 32'(got_addr), 32'(vecs[v].addr[15:2]));
      end
    end

    // Three back-to-back sb with st_valid held high into one word.
    poke(0, 14'd16, 32'h1122_3344);
    req_addr = '{32'h40, 32'h41, 32'h43};
    req_data = '{32'hAA, 32'hBB, 32'hCC};
    waitReady(0);
    we_before   = we_cnt[0];
    st_valid[0] = 1'b1;
    st_type[0]  = 2'd0;
    st_addr[0]  = req_addr[0];
    st_data[0]  = req_data[0];
    for (int r = 0; r < 3; r++) begin
      step();
      checkOutput("b2b_busy", 32'(st_ready[0]), 32'd0);
      guard = 1;
      while (!st_done[0] && guard < 20) begin
        step();
        guard++;
      end
      checkOutput("b2b_latency", 32'(guard), 32'd3);
      if (r < 2) begin
        st_addr[0] = req_addr[r+1];
        st_data[0] = req_data[r+1];
      end else begin
        st_valid[0] = 1'b0;
      end
      step();
      checkOutput("b2b_idle", 32'(st_ready[0]), 32'd1);
    end
    step();
    checkOutput("b2b_we_pulses", 32'(we_cnt[0] - we_before), 32'd3);
    checkOutput("b2b_ram", ram[0][16], 32'hCC22_BBAA);

    resetDuringWait(0);
    resetDuringWait(1);

    // Reset and a request in the same cycle: the request is dropped.
    poke(0, 14'd6, 32'h0BAD_F00D);
    we_before   = we_cnt[0];
    rst[0]      = 1'b1;
    st_valid[0] = 1'b1;
    st_addr[0]  = 32'h18;
    st_data[0]  = 32'h99;
    st_type[0]  = 2'd2;
    step();
    rst[0]      = 1'b0;
    st_valid[0] = 1'b0;
    checkOutput("rstvalid_ready", 32'(st_ready[0]), 32'd1);
    step();
    checkOutput("rstvalid_done", 32'(st_done[0]), 32'd0);
    step();
    checkOutput("rstvalid_we_count", 32'(we_cnt[0] - we_before), 32'd0);
    checkOutput("rstvalid_ram", ram[0][6], 32'h0BAD_F00D);

    // Random stores into a small window of words, upper address bits scrambled.
    for (int g = 0; g < 2; g++) begin
      for (int w = 0; w < 16; w++) begin
        ref_ram[g][w] = $urandom;
        poke(g, 14'(w), ref_ram[g][w]);
      end
    end
    for (int n = 0; n < 80; n++) begin
      inst = $urandom_range(0, 1);
      widx = 4'($urandom_range(0, 15));
      typ  = 2'($urandom_range(0, 3));
      addr = ($urandom & 32'hFFFF_0000) | (32'(widx) << 2) | 32'($urandom_range(0, 3));
      data = $urandom;
      ref_store(ref_ram[inst][widx], addr, data, typ, exp_word, exp_err);
      exp_lat = (exp_err || typ == 2'd2) ? 1 : ((inst == 0) ? 3 : 5);
      applyStimulus(inst, addr, data, typ, got_err, got_wdata, got_addr, lat, we_delta);
      checkOutput("rand_err", 32'(got_err), 32'(exp_err));
      checkOutput("rand_latency", 32'(lat), 32'(exp_lat));
      checkOutput("rand_we_pulses", 32'(we_delta), exp_err ? 32'd0 : 32'd1);
      checkOutput("rand_ram_word", ram[inst][14'(widx)], exp_word);
      ref_ram[inst][widx] = exp_word;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
